// File: rtl/auto_parkcalc_dlmon_pkg.sv
// Shared types and helpers for the parametrised HLS deadlock monitor.
package auto_parkcalc_dlmon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } dlmon_state_e;

    // Ceiling log2, used to size the persistence counter at elaboration.
    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

    // Increment v, holding at the all-ones value of a w-bit field (w <= 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? top : v + 64'd1;
    endfunction

endpackage

// File: rtl/auto_parkcalc_dlmon_persist.sv
// Persistence filter: counts consecutive qualifying cycles and runs the
// IDLE/SUSPECT/BLOCKED state machine. Exposes the registered state plus the
// combinational entering/holding strobes the snapshot logic needs.
module auto_parkcalc_dlmon_persist
    import auto_parkcalc_dlmon_pkg::*;
#(
    parameter int THRESH = 16,
    parameter bit STICKY = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic cand,
    input  logic clear,
    output logic in_blocked,
    output logic enter_pulse,
    output logic entering,
    output logic holding
);

    localparam int PW = clog2(THRESH + 1);
    localparam logic [PW-1:0] THR = PW'(THRESH);

    dlmon_state_e state, state_nxt;
    logic [PW-1:0] persist, persist_nxt;

    // Next-state and persistence count; clear overrides everything.
    always_comb begin
        state_nxt   = state;
        persist_nxt = persist;
        case (state)
            IDLE: begin
                if (cand) begin
                    if (THRESH == 1) begin
                        state_nxt = BLOCKED;
                    end else begin
                        state_nxt   = SUSPECT;
                        persist_nxt = PW'(1);
                    end
                end
            end
            SUSPECT: begin
                if (!cand) begin
                    state_nxt   = IDLE;
                    persist_nxt = '0;
                end else if (persist + PW'(1) == THR) begin
                    state_nxt   = BLOCKED;
                    persist_nxt = '0;
                end else begin
                    persist_nxt = persist + PW'(1);
                end
            end
            BLOCKED: begin
                if (!STICKY && !cand) state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                persist_nxt = '0;
            end
        endcase
        if (clear) begin
            state_nxt   = IDLE;
            persist_nxt = '0;
        end
    end

    assign entering   = (state != BLOCKED) && (state_nxt == BLOCKED);
    assign holding    = (state == BLOCKED) && (state_nxt == BLOCKED);
    assign in_blocked = (state == BLOCKED);

    // State, persistence count and entry pulse registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            persist     <= '0;
            enter_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            persist     <= persist_nxt;
            enter_pulse <= entering;
        end
    end

endmodule

// File: rtl/auto_parkcalc_hls_deadlock_monitor_param.sv
// Deadlock monitor top: qualifies stall conditions, filters them through the
// persistence FSM, and latches diagnostic snapshots plus a duration counter.
module auto_parkcalc_hls_deadlock_monitor_param
    import auto_parkcalc_dlmon_pkg::*;
#(
    parameter int N_AXIS = 3,
    parameter int N_INST = 2,
    parameter int THRESH = 16,
    parameter int CNT_W  = 16,
    parameter bit STICKY = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    output logic              block,
    output logic              block_pulse,
    output logic [N_AXIS-1:0] block_src,
    output logic [N_INST-1:0] block_inst,
    output logic [CNT_W-1:0]  block_cycles
);

    logic [N_INST-1:0] qi;
    logic cand, entering, holding;

    // An instance only counts as stuck if it is blocked and not idle.
    assign qi   = inst_block_sigs & ~inst_idle_sigs;
    assign cand = enable & (|qi) & (|axis_block_sigs);

    auto_parkcalc_dlmon_persist #(
        .THRESH (THRESH),
        .STICKY (STICKY)
    ) u_persist (
        .clock       (clock),
        .reset       (reset),
        .cand        (cand),
        .clear       (clear),
        .in_blocked  (block),
        .enter_pulse (block_pulse),
        .entering    (entering),
        .holding     (holding)
    );

    // Snapshots load on entry, accumulate while blocked, hold after exit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            block_src    <= '0;
            block_inst   <= '0;
            block_cycles <= '0;
        end else if (clear) begin
            block_src    <= '0;
            block_inst   <= '0;
            block_cycles <= '0;
        end else if (entering) begin
            block_src    <= axis_block_sigs;
            block_inst   <= qi;
            block_cycles <= CNT_W'(1);
        end else if (holding) begin
            block_src  <= block_src | axis_block_sigs;
            block_inst <= block_inst | qi;
            // In sticky mode the duration only reflects cycles still deadlocked.
            if (cand) block_cycles <= CNT_W'(sat_inc(64'(block_cycles), CNT_W));
        end
    end

endmodule

// File: tb/tb_auto_parkcalc_hls_deadlock_monitor_param.sv
// Scoreboard bench: three monitor configurations share one stimulus stream.
// A: THRESH=4 STICKY=0 CNT_W=4; B: THRESH=1 STICKY=0 CNT_W=16; C: THRESH=3 STICKY=1 CNT_W=4.
module tb_auto_parkcalc_hls_deadlock_monitor_param;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic [2:0] axis_block_sigs = '0;
    logic [1:0] inst_idle_sigs = '0;
    logic [1:0] inst_block_sigs = '0;

    always #5 clock = ~clock;

    logic a_blk, a_pls, b_blk, b_pls, c_blk, c_pls;
    logic [2:0] a_src, b_src, c_src;
    logic [1:0] a_inst, b_inst, c_inst;
    logic [3:0] a_cyc, c_cyc;
    logic [15:0] b_cyc;

    auto_parkcalc_hls_deadlock_monitor_param #(.N_AXIS(3), .N_INST(2), .THRESH(4), .CNT_W(4), .STICKY(1'b0)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .block(a_blk), .block_pulse(a_pls), .block_src(a_src), .block_inst(a_inst), .block_cycles(a_cyc));

    auto_parkcalc_hls_deadlock_monitor_param #(.N_AXIS(3), .N_INST(2), .THRESH(1), .CNT_W(16), .STICKY(1'b0)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .block(b_blk), .block_pulse(b_pls), .block_src(b_src), .block_inst(b_inst), .block_cycles(b_cyc));

    auto_parkcalc_hls_deadlock_monitor_param #(.N_AXIS(3), .N_INST(2), .THRESH(3), .CNT_W(4), .STICKY(1'b1)) dut_c (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
        .block(c_blk), .block_pulse(c_pls), .block_src(c_src), .block_inst(c_inst), .block_cycles(c_cyc));

    // Reference model: observable outputs plus the length of the current
    // run of consecutive qualifying cycles.
    typedef struct {
        bit         blk;
        bit         pulse;
        logic [2:0] src;
        logic [1:0] inst;
        int         cyc;
        int         run;
    } mdl_t;

    mdl_t ma, mb, mc;
    mdl_t qa[$], qb[$], qc[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic mdl_t zero_m();
        mdl_t z;
        z.blk = 0; z.pulse = 0; z.src = '0; z.inst = '0; z.cyc = 0; z.run = 0;
        return z;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int thresh, input bit sticky, input int cmax,
                                  input bit clr, input bit cnd, input logic [2:0] ax, input logic [1:0] q);
        mdl_t n;
        n = m;
        n.pulse = 0;
        if (clr) return zero_m();
        if (!m.blk) begin
            n.run = cnd ? m.run + 1 : 0;
            if (n.run >= thresh) begin
                n.blk = 1; n.pulse = 1; n.src = ax; n.inst = q; n.cyc = 1; n.run = 0;
            end
        end else if (!sticky && !cnd) begin
            n.blk = 0;
            n.run = 0;
        end else begin
            n.src  = m.src | ax;
            n.inst = m.inst | q;
            if (cnd && m.cyc < cmax) n.cyc = m.cyc + 1;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic blk, input logic pls, input logic [2:0] src,
                       input logic [1:0] inst, input logic [15:0] cyc, input mdl_t e);
        n_cmp++;
        if (blk !== e.blk || pls !== e.pulse || src !== e.src || inst !== e.inst || cyc !== 16'(e.cyc)) begin
            n_bad++;
            $display("FAIL %s @%0t: got blk=%0b pls=%0b src=%b inst=%b cyc=%0d, expected blk=%0b pls=%0b src=%b inst=%b cyc=%0d",
                     nm, $time, blk, pls, src, inst, cyc, e.blk, e.pulse, e.src, e.inst, e.cyc);
        end
    endtask

    // Monitor: every cycle the outputs are presented; compare against the queue head.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (qa.size() > 0) chk("cfgA", a_blk, a_pls, a_src, a_inst, 16'(a_cyc), qa.pop_front());
            if (qb.size() > 0) chk("cfgB", b_blk, b_pls, b_src, b_inst, b_cyc, qb.pop_front());
            if (qc.size() > 0) chk("cfgC", c_blk, c_pls, c_src, c_inst, 16'(c_cyc), qc.pop_front());
        end
    end

    // Apply one cycle of inputs at the falling edge and queue the expected
    // outputs after the following rising edge.
    task automatic drive(input bit rst, input bit en, input bit clr, input logic [2:0] ax,
                         input logic [1:0] idl, input logic [1:0] blkin);
        logic [1:0] q;
        bit cnd;
        @(negedge clock);
        reset = rst; enable = en; clear = clr;
        axis_block_sigs = ax; inst_idle_sigs = idl; inst_block_sigs = blkin;
        q   = blkin & ~idl;
        cnd = en && (q != 0) && (ax != 0);
        if (!rst) begin
            ma = zero_m(); mb = zero_m(); mc = zero_m();
        end else begin
            ma = step(ma, 4, 0, 15, clr, cnd, ax, q);
            mb = step(mb, 1, 0, 65535, clr, cnd, ax, q);
            mc = step(mc, 3, 1, 15, clr, cnd, ax, q);
        end
        qa.push_back(ma); qb.push_back(mb); qc.push_back(mc);
    endtask

    task automatic run(input int n, input bit en, input logic [2:0] ax, input logic [1:0] idl, input logic [1:0] blkin);
        for (int i = 0; i < n; i++) drive(1, en, 0, ax, idl, blkin);
    endtask

    // Assert reset between clock edges and check outputs drop without a clock.
    task automatic async_rst();
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("cfgA_async_reset", a_blk, a_pls, a_src, a_inst, 16'(a_cyc), zero_m());
        chk("cfgB_async_reset", b_blk, b_pls, b_src, b_inst, b_cyc, zero_m());
        chk("cfgC_async_reset", c_blk, c_pls, c_src, c_inst, 16'(c_cyc), zero_m());
        ma = zero_m(); mb = zero_m(); mc = zero_m();
        drive(0, enable, 0, axis_block_sigs, inst_idle_sigs, inst_block_sigs);
        drive(1, 0, 0, 3'b000, 2'b00, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        ma = zero_m(); mb = zero_m(); mc = zero_m();
        // Reset state, then release.
        drive(0, 0, 0, 3'b000, 2'b00, 2'b00);
        drive(0, 1, 0, 3'b001, 2'b00, 2'b01);
        drive(1, 0, 0, 3'b000, 2'b00, 2'b00);
        // Three qualifying cycles then break (idle masks the instance): A must not block.
        run(3, 1, 3'b001, 2'b00, 2'b01);
        run(2, 1, 3'b001, 2'b01, 2'b01);
        // Four qualifying cycles: A blocks on the 4th edge with src=001.
        run(4, 1, 3'b001, 2'b00, 2'b01);
        // Accumulation: src becomes 101, inst becomes 11.
        run(3, 1, 3'b100, 2'b00, 2'b10);
        // Long hold: 4-bit counters saturate at 15.
        run(20, 1, 3'b010, 2'b00, 2'b11);
        // Condition drops: A and B leave BLOCKED, C stays (sticky).
        run(2, 1, 3'b000, 2'b00, 2'b00);
        // Clear with the condition present wins.
        drive(1, 1, 1, 3'b001, 2'b00, 2'b01);
        run(3, 1, 3'b000, 2'b00, 2'b00);
        // Single-cycle condition: B blocks for exactly one cycle with count 1.
        run(1, 1, 3'b001, 2'b00, 2'b01);
        run(3, 1, 3'b000, 2'b00, 2'b00);
        // Enable drop mid-suspect returns to idle.
        run(2, 1, 3'b001, 2'b00, 2'b01);
        run(2, 0, 3'b001, 2'b00, 2'b01);
        run(2, 1, 3'b000, 2'b00, 2'b00);
        // Async reset mid-suspect, then mid-blocked.
        run(2, 1, 3'b011, 2'b00, 2'b01);
        async_rst();
        run(6, 1, 3'b001, 2'b00, 2'b11);
        async_rst();
        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] rax;
            logic [1:0] ridl, rblk;
            rax  = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
            ridl = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            rblk = 2'($urandom);
            if ($urandom_range(0, 99) == 0) async_rst();
            else drive(1, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, rax, ridl, rblk);
        end
        run(2, 1, 3'b000, 2'b00, 2'b00);
        repeat (3) @(posedge clock);
        #2;
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d/%0d/%0d pending, expected 0/0/0", qa.size(), qb.size(), qc.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
